// File: rtl/risc_pkg.sv
// Shared types and encodings for the issue unit and its decoder.
package risc_pkg;

    typedef enum logic [2:0] {
        ADD,
        SUBTRACT,
        XOR,
        OR,
        AND,
        SHIFT_LT_LOG,
        SHIFT_RT_LOG,
        SHIFT_RT_AR
    } ALU_OP_CODE;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH   = 3'd0;
    localparam state_t ST_DECODE  = 3'd1;
    localparam state_t ST_REG_RD  = 3'd2;
    localparam state_t ST_ISSUE   = 3'd3;
    localparam state_t ST_ILLEGAL = 3'd4;

endpackage

// File: rtl/risc_issue_unit_if.sv
// Bundle of fetch, register-read and ALU handshakes around the issue unit.
interface risc_issue_unit_if #(
    parameter int XLEN = 32
);
    import risc_pkg::*;

    logic [XLEN-1:0] mem_rd_addr;
    logic            mem_rd_addr_valid;
    logic [31:0]     mem_rd_data;
    logic            mem_rd_ack;

    logic [4:0]      reg_rd_addr_a;
    logic            reg_rd_addr_a_valid;
    logic [XLEN-1:0] reg_rd_data_a;
    logic            reg_rd_data_a_ack;

    logic [4:0]      reg_rd_addr_b;
    logic            reg_rd_addr_b_valid;
    logic [XLEN-1:0] reg_rd_data_b;
    logic            reg_rd_data_b_ack;

    ALU_OP_CODE      alu_op_code;
    logic [XLEN-1:0] alu_input_A;
    logic [XLEN-1:0] alu_input_B;
    logic [4:0]      alu_reg_addr;
    logic            alu_reg_out;
    logic            alu_inputs_valid;
    logic            done;

    logic [XLEN-1:0] alu_pc_branch_data;
    logic            alu_pc_branch_data_valid;
    logic            alu_pc_branch_data_ack;

    logic            illegal_instr;
    logic [XLEN-1:0] pc;

    modport master (
        output mem_rd_addr, mem_rd_addr_valid,
        input  mem_rd_data, mem_rd_ack,
        output reg_rd_addr_a, reg_rd_addr_a_valid,
        input  reg_rd_data_a, reg_rd_data_a_ack,
        output reg_rd_addr_b, reg_rd_addr_b_valid,
        input  reg_rd_data_b, reg_rd_data_b_ack,
        output alu_op_code, alu_input_A, alu_input_B, alu_reg_addr, alu_reg_out, alu_inputs_valid,
        input  done,
        input  alu_pc_branch_data, alu_pc_branch_data_valid,
        output alu_pc_branch_data_ack,
        output illegal_instr, pc
    );

    modport slave (
        input  mem_rd_addr, mem_rd_addr_valid,
        output mem_rd_data, mem_rd_ack,
        input  reg_rd_addr_a, reg_rd_addr_a_valid,
        output reg_rd_data_a, reg_rd_data_a_ack,
        input  reg_rd_addr_b, reg_rd_addr_b_valid,
        output reg_rd_data_b, reg_rd_data_b_ack,
        input  alu_op_code, alu_input_A, alu_input_B, alu_reg_addr, alu_reg_out, alu_inputs_valid,
        output done,
        output alu_pc_branch_data, alu_pc_branch_data_valid,
        input  alu_pc_branch_data_ack,
        input  illegal_instr, pc
    );

endinterface

// File: rtl/risc_decoder.sv
// Combinational instruction decoder; OP-IMM support is compiled in only
// when RISC_OP_IMM_EN is defined.
module risc_decoder
    import risc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output ALU_OP_CODE      op_code_o,
    output logic            is_r_o,
    output logic            is_i_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic            illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rs1_o  = instr_i[19:15];
    assign rs2_o  = instr_i[24:20];
    assign rd_o   = instr_i[11:7];

    always_comb begin
        op_code_o = ADD;
        is_r_o    = 1'b0;
        is_i_o    = 1'b0;
        imm_o     = '0;
        illegal_o = 1'b1;
        if (opcode == OPC_OP) begin
            is_r_o    = 1'b1;
            illegal_o = 1'b0;
            case ({funct7, funct3})
                {F7_BASE, F3_ADD_SUB}: op_code_o = ADD;
                {F7_ALT,  F3_ADD_SUB}: op_code_o = SUBTRACT;
                {F7_BASE, F3_XOR}:     op_code_o = XOR;
                {F7_BASE, F3_OR}:      op_code_o = OR;
                {F7_BASE, F3_AND}:     op_code_o = AND;
                {F7_BASE, F3_SLL}:     op_code_o = SHIFT_LT_LOG;
                {F7_BASE, F3_SR}:      op_code_o = SHIFT_RT_LOG;
                {F7_ALT,  F3_SR}:      op_code_o = SHIFT_RT_AR;
                default: begin
                    is_r_o    = 1'b0;
                    illegal_o = 1'b1;
                end
            endcase
        end
`ifdef RISC_OP_IMM_EN
        else if (opcode == OPC_OP_IMM) begin
            is_i_o    = 1'b1;
            illegal_o = 1'b0;
            imm_o     = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
            case (funct3)
                F3_ADD_SUB: op_code_o = ADD;
                F3_XOR:     op_code_o = XOR;
                F3_OR:      op_code_o = OR;
                F3_AND:     op_code_o = AND;
                F3_SLL: begin
                    op_code_o = SHIFT_LT_LOG;
                    imm_o     = {{(XLEN-5){1'b0}}, instr_i[24:20]};
                    illegal_o = (funct7 != F7_BASE);
                end
                F3_SR: begin
                    // imm[11:5] selects logical vs arithmetic; shamt is unsigned
                    imm_o     = {{(XLEN-5){1'b0}}, instr_i[24:20]};
                    op_code_o = (funct7 == F7_ALT) ? SHIFT_RT_AR : SHIFT_RT_LOG;
                    illegal_o = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end
                default: illegal_o = 1'b1;
            endcase
            if (illegal_o) is_i_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/risc_issue_unit.sv
// Single-issue sequencer: fetch, decode, register read, ALU issue, retire.
// Define RISC_OP_IMM_EN to enable I-type (OP-IMM) decode.
module risc_issue_unit
    import risc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0,
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
    input logic                clk,
    input logic                reset_n,
    risc_issue_unit_if.master  bus
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            mem_vld_q, mem_vld_d;
    logic [4:0]      ra_addr_q, ra_addr_d;
    logic            ra_vld_q, ra_vld_d;
    logic [4:0]      rb_addr_q, rb_addr_d;
    logic            rb_vld_q, rb_vld_d;
    ALU_OP_CODE      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_out_q, reg_out_d;
    logic            alu_vld_q, alu_vld_d;
    logic            br_ack_q, br_ack_d;
    logic            illegal_q, illegal_d;

    ALU_OP_CODE      dec_op;
    logic            dec_is_r, dec_is_i, dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic [XLEN-1:0] pc_inc, pc_next;

    risc_decoder #(.XLEN(XLEN)) u_dec (
        .instr_i   (instr_q),
        .op_code_o (dec_op),
        .is_r_o    (dec_is_r),
        .is_i_o    (dec_is_i),
        .imm_o     (dec_imm),
        .rs1_o     (dec_rs1),
        .rs2_o     (dec_rs2),
        .rd_o      (dec_rd),
        .illegal_o (dec_illegal)
    );

    assign pc_inc  = pc_q + PC_STEP;
    assign pc_next = bus.alu_pc_branch_data_valid ? bus.alu_pc_branch_data : pc_inc;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        mem_addr_d = mem_addr_q;
        mem_vld_d  = mem_vld_q;
        ra_addr_d  = ra_addr_q;
        ra_vld_d   = ra_vld_q;
        rb_addr_d  = rb_addr_q;
        rb_vld_d   = rb_vld_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rd_d       = rd_q;
        reg_out_d  = reg_out_q;
        alu_vld_d  = alu_vld_q;
        br_ack_d   = 1'b0;
        illegal_d  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // First cycle after reset raises the request; later entries arrive with it set
                if (!mem_vld_q) begin
                    mem_vld_d  = 1'b1;
                    mem_addr_d = pc_q;
                end else if (bus.mem_rd_ack) begin
                    instr_d   = bus.mem_rd_data;
                    mem_vld_d = 1'b0;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                op_d = dec_op;
                rd_d = dec_rd;
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_ILLEGAL;
                end else begin
                    ra_addr_d = dec_rs1;
                    ra_vld_d  = 1'b1;
                    rb_addr_d = dec_rs2;
                    rb_vld_d  = dec_is_r;
                    b_d       = dec_is_i ? dec_imm : '0;
                    state_d   = ST_REG_RD;
                end
            end
            ST_REG_RD: begin
                if (ra_vld_q && bus.reg_rd_data_a_ack) begin
                    a_d      = bus.reg_rd_data_a;
                    ra_vld_d = 1'b0;
                end
                if (rb_vld_q && bus.reg_rd_data_b_ack) begin
                    b_d      = bus.reg_rd_data_b;
                    rb_vld_d = 1'b0;
                end
                if (!ra_vld_d && !rb_vld_d) begin
                    alu_vld_d = 1'b1;
                    reg_out_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.done) begin
                    alu_vld_d  = 1'b0;
                    reg_out_d  = 1'b0;
                    br_ack_d   = bus.alu_pc_branch_data_valid;
                    pc_d       = pc_next;
                    mem_addr_d = pc_next;
                    mem_vld_d  = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_ILLEGAL: begin
                pc_d       = pc_inc;
                mem_addr_d = pc_inc;
                mem_vld_d  = 1'b1;
                state_d    = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= PC_RESET;
            instr_q    <= '0;
            mem_addr_q <= '0;
            mem_vld_q  <= 1'b0;
            ra_addr_q  <= '0;
            ra_vld_q   <= 1'b0;
            rb_addr_q  <= '0;
            rb_vld_q   <= 1'b0;
            op_q       <= ADD;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            reg_out_q  <= 1'b0;
            alu_vld_q  <= 1'b0;
            br_ack_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            mem_addr_q <= mem_addr_d;
            mem_vld_q  <= mem_vld_d;
            ra_addr_q  <= ra_addr_d;
            ra_vld_q   <= ra_vld_d;
            rb_addr_q  <= rb_addr_d;
            rb_vld_q   <= rb_vld_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_q       <= rd_d;
            reg_out_q  <= reg_out_d;
            alu_vld_q  <= alu_vld_d;
            br_ack_q   <= br_ack_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.mem_rd_addr            = mem_addr_q;
    assign bus.mem_rd_addr_valid      = mem_vld_q;
    assign bus.reg_rd_addr_a          = ra_addr_q;
    assign bus.reg_rd_addr_a_valid    = ra_vld_q;
    assign bus.reg_rd_addr_b          = rb_addr_q;
    assign bus.reg_rd_addr_b_valid    = rb_vld_q;
    assign bus.alu_op_code            = op_q;
    assign bus.alu_input_A            = a_q;
    assign bus.alu_input_B            = b_q;
    assign bus.alu_reg_addr           = rd_q;
    assign bus.alu_reg_out            = reg_out_q;
    assign bus.alu_inputs_valid       = alu_vld_q;
    assign bus.alu_pc_branch_data_ack = br_ack_q;
    assign bus.illegal_instr          = illegal_q;
    assign bus.pc                     = pc_q;

endmodule
